// File: rtl/ov7670_pwr_seq.sv
// ov7670_pwr_seq: OV7670 power-up sequencer with SCCB configuration retry and fault latch.
//   i_clk        system clock
//   i_rstn       asynchronous active-low reset
//   i_rst_done   power-on reset generator done (level), starts the one-shot sequence
//   i_cfg_done   SCCB engine success pulse
//   i_cfg_err    SCCB engine NACK/abort pulse
//   o_cam_pwdn   camera PWDN pin (1 = powered down)
//   o_cam_resetn camera RESET# pin (0 = in reset)
//   o_cfg_start  one-cycle start pulse to the SCCB engine, one per attempt
//   o_cam_ready  camera configured (level)
//   o_fault      every configuration attempt failed (level)
//   o_retry_cnt  configuration attempts started
module ov7670_pwr_seq #(
    parameter int unsigned PWDN_CYCLES   = 50000,
    parameter int unsigned RST_CYCLES    = 50000,
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter int unsigned CFG_TIMEOUT   = 5000000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_rst_done,
    input  logic       i_cfg_done,
    input  logic       i_cfg_err,
    output logic       o_cam_pwdn,
    output logic       o_cam_resetn,
    output logic       o_cfg_start,
    output logic       o_cam_ready,
    output logic       o_fault,
    output logic [3:0] o_retry_cnt
);
    typedef enum logic [3:0] {
        IDLE, PWDN_HOLD, RST_HOLD, SETTLE, CFG_KICK, CFG_WAIT, RETRY_CHK, READY, FAULT
    } state_t;

    localparam int unsigned MAX_AB  = PWDN_CYCLES > RST_CYCLES ? PWDN_CYCLES : RST_CYCLES;
    localparam int unsigned MAX_ABC = MAX_AB > SETTLE_CYCLES ? MAX_AB : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = MAX_ABC > CFG_TIMEOUT ? MAX_ABC : CFG_TIMEOUT;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             cnt_zero, pwdn_nxt, resetn_nxt;

    assign cnt_zero = cnt == '0;

    // Every timed state loads N-1 on entry and leaves when the shared counter reads 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_zero ? cnt : cnt - 1'b1;
        case (state)
            IDLE:
                if (i_rst_done) begin
                    state_nxt = PWDN_HOLD;
                    cnt_nxt   = CNT_W'(PWDN_CYCLES - 1);
                end
            PWDN_HOLD:
                if (cnt_zero) begin
                    state_nxt = RST_HOLD;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end
            RST_HOLD:
                if (cnt_zero) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                end
            SETTLE:
                if (cnt_zero) state_nxt = CFG_KICK;
            CFG_KICK: begin
                state_nxt = CFG_WAIT;
                cnt_nxt   = CNT_W'(CFG_TIMEOUT - 1);
            end
            CFG_WAIT:
                if (i_cfg_done) state_nxt = READY;
                else if (i_cfg_err || cnt_zero) state_nxt = RETRY_CHK;
            RETRY_CHK:
                if (o_retry_cnt < 4'(MAX_RETRY)) begin
                    state_nxt = RST_HOLD;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end else begin
                    state_nxt = FAULT;
                end
            default: state_nxt = state;
        endcase
        retry_nxt  = o_retry_cnt + 4'(state_nxt == CFG_KICK);
        pwdn_nxt   = state_nxt inside {IDLE, PWDN_HOLD, FAULT};
        resetn_nxt = !(state_nxt inside {IDLE, PWDN_HOLD, RST_HOLD, FAULT});
    end

    // Outputs are registered from the next state so pins move on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            o_retry_cnt  <= '0;
            o_cam_pwdn   <= 1'b1;
            o_cam_resetn <= 1'b0;
            o_cfg_start  <= 1'b0;
            o_cam_ready  <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o_retry_cnt  <= retry_nxt;
            o_cam_pwdn   <= pwdn_nxt;
            o_cam_resetn <= resetn_nxt;
            o_cfg_start  <= state_nxt == CFG_KICK;
            o_cam_ready  <= state_nxt == READY;
            o_fault      <= state_nxt == FAULT;
        end
    end

    always_ff @(posedge i_clk) begin
        assert (PWDN_CYCLES != 0 && RST_CYCLES != 0 && SETTLE_CYCLES != 0 && CFG_TIMEOUT != 0)
            else $error("ov7670_pwr_seq: cycle parameters must be non-zero");
        assert (MAX_RETRY >= 1 && MAX_RETRY <= 15)
            else $error("ov7670_pwr_seq: MAX_RETRY must be 1..15");
        assert (((64'(MAX_CYC) - 64'd1) >> CNT_W) == 64'd0)
            else $error("ov7670_pwr_seq: CNT_W too narrow for cycle parameters");
        assert (!(o_cam_ready && o_fault))
            else $error("ov7670_pwr_seq: ready and fault both high");
    end
endmodule

// File: tb/tb_ov7670_pwr_seq.sv
// tb_ov7670_pwr_seq: self-checking bench for ov7670_pwr_seq (timed pin edges via event scoreboard).
module tb_ov7670_pwr_seq;
    localparam int PW = 10, RS = 10, ST = 10, TO = 100, MAX_RETRY = 3, DLY = 20;
    localparam int A_DONE = 0, A_ERR = 1, A_TO = 2, A_BOTH = 3;
    localparam int K_PWF = 0, K_PWR = 1, K_RNF = 2, K_RNR = 3, K_START = 4, K_READY = 5, K_FAULT = 6;

    typedef struct {
        string name;
        int    act[3];
        bit    stray;
        bit    rdy;
        bit    flt;
        int    retry;
        bit    pwdn;
        bit    rstn;
    } vec_t;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic       i_clk = 0, i_rstn = 0, i_rst_done = 0, i_cfg_done = 0, i_cfg_err = 0;
    logic       o_cam_pwdn, o_cam_resetn, o_cfg_start, o_cam_ready, o_fault;
    logic [3:0] o_retry_cnt;

    int   cyc = 0, pass_cnt = 0, total_cnt = 0;
    bit   mon_en = 0;
    logic pw_p = 1, rn_p = 0, rd_p = 0, ft_p = 0;
    ev_t  sb[$];
    vec_t vecs[7];

    ov7670_pwr_seq #(
        .PWDN_CYCLES(PW), .RST_CYCLES(RS), .SETTLE_CYCLES(ST),
        .CFG_TIMEOUT(TO), .MAX_RETRY(MAX_RETRY), .CNT_W(32)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_rst_done(i_rst_done),
        .i_cfg_done(i_cfg_done), .i_cfg_err(i_cfg_err),
        .o_cam_pwdn(o_cam_pwdn), .o_cam_resetn(o_cam_resetn), .o_cfg_start(o_cfg_start),
        .o_cam_ready(o_cam_ready), .o_fault(o_fault), .o_retry_cnt(o_retry_cnt)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
        else pass_cnt++;
    endtask

    task automatic push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic got_ev(input int k);
        ev_t e;
        total_cnt++;
        if (sb.size() == 0) begin
            $display("FAIL sb_event: unexpected kind=%0d at cycle %0d, nothing expected", k, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc)
                $display("FAIL sb_event: got kind=%0d cycle=%0d expected kind=%0d cycle=%0d",
                         k, cyc, e.kind, e.cyc);
            else pass_cnt++;
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (pw_p && !o_cam_pwdn) got_ev(K_PWF);
            if (!pw_p && o_cam_pwdn) got_ev(K_PWR);
            if (rn_p && !o_cam_resetn) got_ev(K_RNF);
            if (!rn_p && o_cam_resetn) got_ev(K_RNR);
            if (o_cfg_start) got_ev(K_START);
            if (!rd_p && o_cam_ready) got_ev(K_READY);
            if (!ft_p && o_fault) got_ev(K_FAULT);
        end
        pw_p = o_cam_pwdn;
        rn_p = o_cam_resetn;
        rd_p = o_cam_ready;
        ft_p = o_fault;
    end

    function automatic vec_t mk(input string n, input int a0, input int a1, input int a2,
                                input bit st, input bit rdy, input int rc);
        vec_t v;
        v.name   = n;
        v.act[0] = a0;
        v.act[1] = a1;
        v.act[2] = a2;
        v.stray  = st;
        v.rdy    = rdy;
        v.flt    = !rdy;
        v.retry  = rc;
        v.pwdn   = !rdy;
        v.rstn   = rdy;
        return v;
    endfunction

    // Called right after a falling edge; reset lands mid low phase so the async path is observed.
    task automatic apply_reset();
        #2;
        mon_en = 0;
        i_rstn = 0;
        i_rst_done = 0;
        i_cfg_done = 0;
        i_cfg_err = 0;
        #1;
        chk("rst_pwdn", o_cam_pwdn, 1);
        chk("rst_resetn", o_cam_resetn, 0);
        chk("rst_start", o_cfg_start, 0);
        chk("rst_ready", o_cam_ready, 0);
        chk("rst_fault", o_fault, 0);
        chk("rst_retry", o_retry_cnt, 0);
        sb.delete();
        @(negedge i_clk);
        i_rstn = 1;
        @(negedge i_clk);
        mon_en = 1;
    endtask

    task automatic kick(output int t);
        @(negedge i_clk);
        i_rst_done = 1;
        t = cyc + 1;
        push(K_PWF, t + PW);
        push(K_RNR, t + PW + RS);
        push(K_START, t + PW + RS + ST);
    endtask

    // e = edge at which the failure (err or timeout) is taken in CFG_WAIT.
    task automatic push_retry(input int a, input int e);
        if (a + 1 < MAX_RETRY) begin
            push(K_RNF, e + 1);
            push(K_RNR, e + 1 + RS);
            push(K_START, e + 1 + RS + ST);
        end else begin
            push(K_PWR, e + 1);
            push(K_RNF, e + 1);
            push(K_FAULT, e + 1);
        end
    endtask

    task automatic run_seq(input vec_t v);
        int  t, s, n;
        bit  found;
        kick(t);
        if (v.stray) begin
            while (cyc < t + PW + RS + 4) @(negedge i_clk);
            i_cfg_done = 1;
            @(negedge i_clk);
            i_cfg_done = 0;
        end
        for (int a = 0; a < MAX_RETRY; a++) begin
            found = 0;
            n = 0;
            while (!found && n < 400) begin
                if (o_cfg_start) found = 1;
                else begin
                    @(negedge i_clk);
                    n++;
                end
            end
            if (!found) begin
                total_cnt++;
                $display("FAIL %s start_wait: no o_cfg_start for attempt %0d within 400 cycles", v.name, a + 1);
                break;
            end
            s = cyc;
            if (v.act[a] == A_TO) begin
                push_retry(a, s + 1 + TO);
                @(negedge i_clk);
                continue;
            end
            repeat (DLY) @(negedge i_clk);
            i_cfg_done = v.act[a] inside {A_DONE, A_BOTH};
            i_cfg_err  = v.act[a] inside {A_ERR, A_BOTH};
            if (i_cfg_done) push(K_READY, cyc + 1);
            else push_retry(a, cyc + 1);
            @(negedge i_clk);
            i_cfg_done = 0;
            i_cfg_err = 0;
            if (v.act[a] != A_ERR) break;
        end
        if (v.stray) begin
            repeat (5) @(negedge i_clk);
            i_cfg_err = 1;
            @(negedge i_clk);
            i_cfg_err = 0;
        end
        repeat (130) @(negedge i_clk);
        chk({v.name, "_ready"}, o_cam_ready, v.rdy);
        chk({v.name, "_fault"}, o_fault, v.flt);
        chk({v.name, "_retry"}, o_retry_cnt, v.retry);
        chk({v.name, "_pwdn"}, o_cam_pwdn, v.pwdn);
        chk({v.name, "_resetn"}, o_cam_resetn, v.rstn);
        chk({v.name, "_start_idle"}, o_cfg_start, 0);
        chk({v.name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        int t;
        vecs[0] = mk("nominal", A_DONE, A_DONE, A_DONE, 0, 1, 1);
        vecs[1] = mk("err_then_done", A_ERR, A_DONE, A_DONE, 0, 1, 2);
        vecs[2] = mk("timeout_x3", A_TO, A_TO, A_TO, 0, 0, 3);
        vecs[3] = mk("done_err_same", A_BOTH, A_DONE, A_DONE, 0, 1, 1);
        vecs[4] = mk("stray_pulses", A_DONE, A_DONE, A_DONE, 1, 1, 1);
        vecs[5] = mk("last_try_ok", A_ERR, A_TO, A_DONE, 0, 1, 3);
        vecs[6] = mk("err_x3", A_ERR, A_ERR, A_ERR, 0, 0, 3);
        repeat (2) @(negedge i_clk);
        foreach (vecs[i]) begin
            apply_reset();
            run_seq(vecs[i]);
        end
        apply_reset();
        kick(t);
        while (cyc < t + PW + RS / 2) @(negedge i_clk);
        apply_reset();
        run_seq(vecs[0]);
        apply_reset();
        kick(t);
        while (cyc < t + PW + RS + ST + 10) @(negedge i_clk);
        chk("mid_wait_retry", o_retry_cnt, 1);
        apply_reset();
        run_seq(vecs[0]);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
